philv_fetch_unit: RTL and testbench

Instruction fetch stage for the Philosophy-V multicycle core. Owns the program counter, drives the instruction port of the synchronous dual-port memory, captures the returned word and presents it to the instruction register / decode stage with a valid/ready handshake. Accepts PC redirects from the execute stage for branches and jumps, and flags misaligned or out-of-range fetches.

---
 rtl/philv_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_philv_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/philv_fetch_unit.sv
// Philosophy-V instruction fetch stage: owns the PC, reads instruction memory port 0
// and hands fetched words to decode through a valid/ready handshake.
module philv_fetch_unit #(
  parameter int                   BUS_WIDTH = 32,
  parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0,
  parameter int                   I_MEM_LEN = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic                 mem_rd_ena,
  input  logic [BUS_WIDTH-1:0] mem_rdata,
  output logic [BUS_WIDTH-1:0] instr,
  output logic [BUS_WIDTH-1:0] instr_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 redirect_valid,
  input  logic [BUS_WIDTH-1:0] redirect_target,
  output logic                 misaligned,
  output logic                 fault
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  // Byte limit is kept two bits wider than the bus so 4*I_MEM_LEN cannot overflow.
  localparam logic [BUS_WIDTH+1:0] MEM_LIMIT = (BUS_WIDTH+2)'(I_MEM_LEN) << 2;
  localparam logic [BUS_WIDTH-1:0] PC_STEP   = {{(BUS_WIDTH-3){1'b0}}, 3'b100};

  function automatic logic [BUS_WIDTH-1:0] word_align(input logic [BUS_WIDTH-1:0] addr);
    return {addr[BUS_WIDTH-1:2], 2'b00};
  endfunction

  state_t               state_r, state_nxt_s;
  logic [BUS_WIDTH-1:0] pc_r, pc_nxt_s;
  logic [BUS_WIDTH-1:0] instr_r, instr_nxt_s;
  logic [BUS_WIDTH-1:0] instr_pc_r, instr_pc_nxt_s;
  logic                 valid_r, valid_nxt_s;
  logic                 misaligned_r, misaligned_nxt_s;
  logic                 fault_r, fault_nxt_s;
  logic                 out_of_range_s;
  logic                 rd_ena_s;

  assign out_of_range_s = ({2'b00, pc_r} >= MEM_LIMIT);

  // Next-state and register-update decode; a redirect overrides the per-state result.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    instr_nxt_s      = instr_r;
    instr_pc_nxt_s   = instr_pc_r;
    valid_nxt_s      = valid_r;
    misaligned_nxt_s = misaligned_r;
    fault_nxt_s      = fault_r;
    rd_ena_s         = 1'b0;

    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (out_of_range_s) begin
          fault_nxt_s = 1'b1;
          state_nxt_s = ST_FAULT;
        end else begin
          rd_ena_s    = 1'b1;
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        instr_nxt_s    = mem_rdata;
        instr_pc_nxt_s = pc_r;
        valid_nxt_s    = 1'b1;
        state_nxt_s    = ST_HOLD;
      end
      ST_HOLD: begin
        if (instr_ready) begin
          pc_nxt_s    = pc_r + PC_STEP;
          valid_nxt_s = 1'b0;
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_FAULT: begin
        valid_nxt_s = 1'b0;
        state_nxt_s = ST_FAULT;
      end
      default: begin
        valid_nxt_s = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase

    // Redirect discards any in-flight read and wins over a same-cycle handshake.
    if (redirect_valid && (state_r != ST_FAULT)) begin
      pc_nxt_s    = word_align(redirect_target);
      valid_nxt_s = 1'b0;
      fault_nxt_s = fault_r;
      state_nxt_s = ST_FETCH;
      if (redirect_target[1:0] != 2'b00) begin
        misaligned_nxt_s = 1'b1;
      end else begin
        misaligned_nxt_s = misaligned_r;
      end
    end else begin
      misaligned_nxt_s = misaligned_nxt_s;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      pc_r         <= RESET_PC;
      instr_r      <= '0;
      instr_pc_r   <= '0;
      valid_r      <= 1'b0;
      misaligned_r <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      instr_r      <= instr_nxt_s;
      instr_pc_r   <= instr_pc_nxt_s;
      valid_r      <= valid_nxt_s;
      misaligned_r <= misaligned_nxt_s;
      fault_r      <= fault_nxt_s;
    end
  end

  // Memory strobe depends only on state and pc registers.
  assign mem_addr    = pc_r;
  assign mem_rd_ena  = rd_ena_s;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign instr_valid = valid_r;
  assign misaligned  = misaligned_r;
  assign fault       = fault_r;

endmodule

// File: tb/tb_philv_fetch_unit.sv
// Self-checking bench for philv_fetch_unit: scoreboard of expected (instr, pc) pairs
// against two instances (full-size memory and a 4-word memory for the fault case).
module tb_philv_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, instr_ready_a, redirect_valid_a;
  logic [31:0] redirect_target_a, mem_addr_a, mem_rdata_a, instr_a, instr_pc_a;
  logic        mem_rd_ena_a, instr_valid_a, misaligned_a, fault_a;

  logic        rst_b, instr_ready_b, redirect_valid_b;
  logic [31:0] redirect_target_b, mem_addr_b, mem_rdata_b, instr_b, instr_pc_b;
  logic        mem_rd_ena_b, instr_valid_b, misaligned_b, fault_b;

  logic [31:0] mem [0:255];

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  philv_fetch_unit #(.BUS_WIDTH(32), .RESET_PC(32'h0000_0000), .I_MEM_LEN(256)) dut_a (
    .clk(clk), .rst(rst_a), .mem_addr(mem_addr_a), .mem_rd_ena(mem_rd_ena_a),
    .mem_rdata(mem_rdata_a), .instr(instr_a), .instr_pc(instr_pc_a),
    .instr_valid(instr_valid_a), .instr_ready(instr_ready_a),
    .redirect_valid(redirect_valid_a), .redirect_target(redirect_target_a),
    .misaligned(misaligned_a), .fault(fault_a));

  philv_fetch_unit #(.BUS_WIDTH(32), .RESET_PC(32'h0000_0000), .I_MEM_LEN(4)) dut_b (
    .clk(clk), .rst(rst_b), .mem_addr(mem_addr_b), .mem_rd_ena(mem_rd_ena_b),
    .mem_rdata(mem_rdata_b), .instr(instr_b), .instr_pc(instr_pc_b),
    .instr_valid(instr_valid_b), .instr_ready(instr_ready_b),
    .redirect_valid(redirect_valid_b), .redirect_target(redirect_target_b),
    .misaligned(misaligned_b), .fault(fault_b));

  // Synchronous read memory: data valid one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_ena_a) mem_rdata_a <= mem[mem_addr_a[9:2]];
    if (mem_rd_ena_b) mem_rdata_b <= mem[mem_addr_b[9:2]];
  end

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.instr = mem[pc[9:2]];
    e.pc    = pc;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a(input logic ready);
    rst_a = 1'b1; instr_ready_a = ready; redirect_valid_a = 1'b0; redirect_target_a = 32'h0;
    sb_q.delete();
    step(); step();
    rst_a = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; instr_ready_a = 1'b1; redirect_valid_a = 1'b0; redirect_target_a = 32'h0;
    step(); step();
    n_cmp++; if (instr_valid_a !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", instr_valid_a); end
    n_cmp++; if (mem_rd_ena_a !== 1'b0) begin n_err++; $display("FAIL reset_rd_ena: got %b want 0", mem_rd_ena_a); end
    n_cmp++; if (mem_addr_a !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", mem_addr_a); end
    n_cmp++; if (instr_a !== 32'h0 || instr_pc_a !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h/%h want 0/0", instr_a, instr_pc_a); end
    n_cmp++; if (misaligned_a !== 1'b0 || fault_a !== 1'b0) begin n_err++; $display("FAIL reset_flags: got %b/%b want 0/0", misaligned_a, fault_a); end
  endtask

  task automatic test_sequence();
    exp_t e;
    reset_a(1'b1);
    for (int i = 0; i < 4; i++) sb_q.push_back(mk(32'(4 * i)));
    for (int k = 1; k <= 12; k++) begin
      step();
      n_cmp++;
      if (instr_valid_a !== ((k % 3) == 0)) begin n_err++; $display("FAIL seq_valid edge %0d: got %b want %b", k, instr_valid_a, ((k % 3) == 0)); end
      n_cmp++;
      if (mem_rd_ena_a !== ((k % 3) == 1)) begin n_err++; $display("FAIL seq_rd_ena edge %0d: got %b want %b", k, mem_rd_ena_a, ((k % 3) == 1)); end
      if ((k % 3) == 1) begin
        n_cmp++;
        if (mem_addr_a !== 32'(4 * ((k - 1) / 3))) begin n_err++; $display("FAIL seq_addr edge %0d: got %h want %h", k, mem_addr_a, 32'(4 * ((k - 1) / 3))); end
      end
      if (instr_valid_a === 1'b1) begin
        n_cmp++;
        if (sb_q.size() == 0) begin n_err++; $display("FAIL seq_extra: got pc %h want none", instr_pc_a); end
        else begin
          e = sb_q.pop_front();
          if (instr_a !== e.instr || instr_pc_a !== e.pc) begin n_err++; $display("FAIL seq_data: got %h@%h want %h@%h", instr_a, instr_pc_a, e.instr, e.pc); end
        end
      end
    end
    n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL seq_missing: got %0d left want 0", sb_q.size()); end
  endtask

  task automatic test_stall();
    bit found = 1'b0;
    reset_a(1'b1);
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (instr_valid_a === 1'b1 && instr_pc_a === 32'h4) begin found = 1'b1; instr_ready_a = 1'b0; end
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL stall_reach: got none want HOLD at pc 4"); end
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (instr_valid_a !== 1'b1 || instr_a !== 32'h00A00113 || instr_pc_a !== 32'h4 || mem_rd_ena_a !== 1'b0) begin
        n_err++; $display("FAIL stall_hold cyc %0d: got v=%b %h@%h rd=%b want v=1 00a00113@4 rd=0", i, instr_valid_a, instr_a, instr_pc_a, mem_rd_ena_a);
      end
    end
    instr_ready_a = 1'b1;
    step();
    n_cmp++;
    if (mem_rd_ena_a !== 1'b1 || mem_addr_a !== 32'h8 || instr_valid_a !== 1'b0) begin
      n_err++; $display("FAIL stall_release: got rd=%b addr=%h v=%b want rd=1 addr=8 v=0", mem_rd_ena_a, mem_addr_a, instr_valid_a);
    end
  endtask

  task automatic test_redirect_wait();
    exp_t e;
    bit found = 1'b0;
    reset_a(1'b1);
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (mem_rd_ena_a === 1'b1 && mem_addr_a === 32'h8) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL rdw_reach: got none want FETCH at 8"); end
    step();
    redirect_valid_a = 1'b1; redirect_target_a = 32'h40;
    sb_q.push_back(mk(32'h40));
    step();
    redirect_valid_a = 1'b0;
    n_cmp++;
    if (mem_rd_ena_a !== 1'b1 || mem_addr_a !== 32'h40 || instr_valid_a !== 1'b0) begin
      n_err++; $display("FAIL rdw_fetch: got rd=%b addr=%h v=%b want rd=1 addr=40 v=0", mem_rd_ena_a, mem_addr_a, instr_valid_a);
    end
    step();
    n_cmp++; if (instr_valid_a !== 1'b0) begin n_err++; $display("FAIL rdw_early: got v=%b pc=%h want v=0", instr_valid_a, instr_pc_a); end
    step();
    n_cmp++;
    e = sb_q.pop_front();
    if (instr_valid_a !== 1'b1 || instr_a !== e.instr || instr_pc_a !== e.pc) begin
      n_err++; $display("FAIL rdw_data: got v=%b %h@%h want v=1 %h@%h", instr_valid_a, instr_a, instr_pc_a, e.instr, e.pc);
    end
    n_cmp++; if (misaligned_a !== 1'b0) begin n_err++; $display("FAIL rdw_misaligned: got %b want 0", misaligned_a); end
  endtask

  task automatic test_redirect_hold();
    exp_t e;
    bit found = 1'b0;
    reset_a(1'b0);
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (instr_valid_a === 1'b1) found = 1'b1;
    end
    n_cmp++; if (!found || instr_pc_a !== 32'h0) begin n_err++; $display("FAIL rdh_reach: got pc %h want 0", instr_pc_a); end
    instr_ready_a = 1'b1; redirect_valid_a = 1'b1; redirect_target_a = 32'h46;
    sb_q.push_back(mk(32'h44));
    step();
    redirect_valid_a = 1'b0;
    n_cmp++;
    if (misaligned_a !== 1'b1 || mem_rd_ena_a !== 1'b1 || mem_addr_a !== 32'h44 || instr_valid_a !== 1'b0) begin
      n_err++; $display("FAIL rdh_fetch: got mis=%b rd=%b addr=%h v=%b want mis=1 rd=1 addr=44 v=0", misaligned_a, mem_rd_ena_a, mem_addr_a, instr_valid_a);
    end
    step(); step();
    n_cmp++;
    e = sb_q.pop_front();
    if (instr_valid_a !== 1'b1 || instr_a !== e.instr || instr_pc_a !== e.pc) begin
      n_err++; $display("FAIL rdh_data: got v=%b %h@%h want v=1 %h@%h", instr_valid_a, instr_a, instr_pc_a, e.instr, e.pc);
    end
    step();
    n_cmp++; if (misaligned_a !== 1'b1 || mem_addr_a !== 32'h48) begin n_err++; $display("FAIL rdh_sticky: got mis=%b addr=%h want mis=1 addr=48", misaligned_a, mem_addr_a); end
  endtask

  task automatic test_fault();
    exp_t e;
    bit bad_rd = 1'b0;
    bit found = 1'b0;
    rst_b = 1'b1; instr_ready_b = 1'b1; redirect_valid_b = 1'b0; redirect_target_b = 32'h0;
    sb_q.delete();
    step(); step();
    rst_b = 1'b0;
    for (int i = 0; i < 4; i++) sb_q.push_back(mk(32'(4 * i)));
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (mem_rd_ena_b === 1'b1 && mem_addr_b >= 32'd16) bad_rd = 1'b1;
      if (instr_valid_b === 1'b1) begin
        n_cmp++;
        if (sb_q.size() == 0) begin n_err++; $display("FAIL flt_extra: got pc %h want none", instr_pc_b); end
        else begin
          e = sb_q.pop_front();
          if (instr_b !== e.instr || instr_pc_b !== e.pc) begin n_err++; $display("FAIL flt_data: got %h@%h want %h@%h", instr_b, instr_pc_b, e.instr, e.pc); end
        end
      end
      if (fault_b === 1'b1) found = 1'b1;
    end
    n_cmp++; if (!found || sb_q.size() != 0) begin n_err++; $display("FAIL flt_set: got fault=%b left=%0d want fault=1 left=0", fault_b, sb_q.size()); end
    n_cmp++; if (bad_rd || mem_addr_b !== 32'd16) begin n_err++; $display("FAIL flt_rd: got bad_rd=%b addr=%h want 0/10", bad_rd, mem_addr_b); end
    redirect_valid_b = 1'b1; redirect_target_b = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (fault_b !== 1'b1 || mem_rd_ena_b !== 1'b0 || instr_valid_b !== 1'b0 || mem_addr_b !== 32'd16) begin
        n_err++; $display("FAIL flt_absorb: got f=%b rd=%b v=%b addr=%h want 1/0/0/10", fault_b, mem_rd_ena_b, instr_valid_b, mem_addr_b);
      end
    end
    redirect_valid_b = 1'b0;
    rst_b = 1'b1;
    #1;
    n_cmp++; if (fault_b !== 1'b0 || mem_addr_b !== 32'h0) begin n_err++; $display("FAIL flt_clear: got f=%b addr=%h want 0/0", fault_b, mem_addr_b); end
    step();
    rst_b = 1'b0;
    step(); step(); step();
    n_cmp++;
    if (instr_valid_b !== 1'b1 || instr_pc_b !== 32'h0 || instr_b !== 32'h00500093) begin
      n_err++; $display("FAIL flt_restart: got v=%b %h@%h want v=1 00500093@0", instr_valid_b, instr_b, instr_pc_b);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    bit found = 1'b0;
    reset_a(1'b1);
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (mem_rd_ena_a === 1'b1 && mem_addr_a === 32'h8) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL ar_reach: got none want FETCH at 8"); end
    step();
    #2;
    rst_a = 1'b1;
    #1;
    n_cmp++;
    if (instr_valid_a !== 1'b0 || mem_rd_ena_a !== 1'b0 || mem_addr_a !== 32'h0 || instr_a !== 32'h0 || instr_pc_a !== 32'h0) begin
      n_err++; $display("FAIL ar_immediate: got v=%b rd=%b addr=%h %h@%h want 0/0/0 0@0", instr_valid_a, mem_rd_ena_a, mem_addr_a, instr_a, instr_pc_a);
    end
    sb_q.delete();
    sb_q.push_back(mk(32'h0));
    step();
    rst_a = 1'b0;
    step();
    n_cmp++; if (mem_rd_ena_a !== 1'b1 || mem_addr_a !== 32'h0) begin n_err++; $display("FAIL ar_fetch: got rd=%b addr=%h want 1/0", mem_rd_ena_a, mem_addr_a); end
    step(); step();
    n_cmp++;
    e = sb_q.pop_front();
    if (instr_valid_a !== 1'b1 || instr_a !== e.instr || instr_pc_a !== e.pc) begin
      n_err++; $display("FAIL ar_data: got v=%b %h@%h want v=1 %h@%h", instr_valid_a, instr_a, instr_pc_a, e.instr, e.pc);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i * 32'h0001_0101);
    mem[0] = 32'h00500093;
    mem[1] = 32'h00A00113;
    mem[2] = 32'h002081B3;
    mem[3] = 32'h00000013;
    rst_b = 1'b1; instr_ready_b = 1'b1; redirect_valid_b = 1'b0; redirect_target_b = 32'h0;
    test_reset();
    test_sequence();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_fault();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
